// File: rtl/controle_jogo.sv
// Game-state sequencer: lives, score, enemy respawn and post-hit invulnerability.
// Every output is a flop loaded from the next-state values, so inputs act one cycle later.
module controle_jogo #(
  parameter int unsigned VIDAS_INICIAIS  = 3,
  parameter int unsigned QUADROS_INVULN  = 60,
  parameter int unsigned QUADROS_RESPAWN = 90,
  parameter int unsigned PONTOS_MAX      = 999
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       colisao_nave,
  input  logic       colisao_inimigo,
  output logic       ativo,
  output logic       perdeu,
  output logic       inimigo_vivo,
  output logic       nave_visivel,
  output logic [2:0] vidas,
  output logic [9:0] pontos,
  output logic       atualizar
);

  typedef enum logic [1:0] {StEspera, StJogando, StInvuln, StFim} estado_e;

  estado_e     estado_q, estado_d;
  logic        start_q;
  logic [7:0]  invuln_q, invuln_d;
  logic [7:0]  respawn_q, respawn_d;
  logic [2:0]  vidas_q, vidas_d;
  logic [9:0]  pontos_q, pontos_d;
  logic        vivo_q, vivo_d;
  logic        ativo_q, ativo_d;
  logic        perdeu_q, perdeu_d;
  logic        visivel_q, visivel_d;
  logic        atualizar_q, atualizar_d;
  logic        start_edge;
  logic        jogando;

  assign start_edge = start & ~start_q;
  assign jogando    = (estado_q == StJogando) || (estado_q == StInvuln);

  always_comb begin
    estado_d  = estado_q;
    invuln_d  = invuln_q;
    respawn_d = respawn_q;
    vidas_d   = vidas_q;
    pontos_d  = pontos_q;
    vivo_d    = vivo_q;

    unique case (estado_q)
      StEspera, StFim: begin
        if (start_edge) begin
          estado_d  = StJogando;
          vidas_d   = 3'(VIDAS_INICIAIS);
          pontos_d  = '0;
          vivo_d    = 1'b1;
          respawn_d = '0;
          invuln_d  = '0;
        end
      end
      StJogando: begin
        if (colisao_nave) begin
          if (vidas_q > 3'd1) begin
            vidas_d  = vidas_q - 3'd1;
            invuln_d = '0;
            estado_d = StInvuln;
          end else begin
            vidas_d  = '0;
            estado_d = StFim;
          end
        end
      end
      StInvuln: begin
        if (frame_tick) begin
          if (invuln_q == 8'(QUADROS_INVULN - 1)) begin
            estado_d = StJogando;
          end else begin
            invuln_d = invuln_q + 8'd1;
          end
        end
      end
      default: estado_d = StEspera;
    endcase

    // Enemy logic runs alongside a ship hit, so a fatal double hit still scores.
    if (jogando) begin
      if (vivo_q) begin
        if (colisao_inimigo) begin
          if (pontos_q < 10'(PONTOS_MAX)) pontos_d = pontos_q + 10'd1;
          vivo_d    = 1'b0;
          respawn_d = '0;
        end
      end else if (frame_tick) begin
        if (respawn_q == 8'(QUADROS_RESPAWN - 1)) begin
          vivo_d = 1'b1;
        end else begin
          respawn_d = respawn_q + 8'd1;
        end
      end
    end

    ativo_d     = (estado_d != StEspera);
    perdeu_d    = (estado_d == StFim);
    visivel_d   = (estado_d == StInvuln) ? ~invuln_d[3] : 1'b1;
    atualizar_d = frame_tick & jogando;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      estado_q    <= StEspera;
      start_q     <= 1'b0;
      invuln_q    <= '0;
      respawn_q   <= '0;
      vidas_q     <= '0;
      pontos_q    <= '0;
      vivo_q      <= 1'b0;
      ativo_q     <= 1'b0;
      perdeu_q    <= 1'b0;
      visivel_q   <= 1'b1;
      atualizar_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      start_q     <= start;
      invuln_q    <= invuln_d;
      respawn_q   <= respawn_d;
      vidas_q     <= vidas_d;
      pontos_q    <= pontos_d;
      vivo_q      <= vivo_d;
      ativo_q     <= ativo_d;
      perdeu_q    <= perdeu_d;
      visivel_q   <= visivel_d;
      atualizar_q <= atualizar_d;
    end
  end

  assign ativo        = ativo_q;
  assign perdeu       = perdeu_q;
  assign inimigo_vivo = vivo_q;
  assign nave_visivel = visivel_q;
  assign vidas        = vidas_q;
  assign pontos       = pontos_q;
  assign atualizar    = atualizar_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Directed bench for controle_jogo; stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares. dut_b uses a one-frame respawn for the score test.
module tb_controle_jogo;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst, ft, st, cn, ci, sel;

  logic       a_ativo, a_perdeu, a_vivo, a_vis, a_atu;
  logic [2:0] a_vidas;
  logic [9:0] a_pontos;
  logic       b_ativo, b_perdeu, b_vivo, b_vis, b_atu;
  logic [2:0] b_vidas;
  logic [9:0] b_pontos;

  controle_jogo dut_a (
    .CLOCK_50       (clk),
    .reset          (rst),
    .frame_tick     (ft & ~sel),
    .start          (st & ~sel),
    .colisao_nave   (cn & ~sel),
    .colisao_inimigo(ci & ~sel),
    .ativo          (a_ativo),
    .perdeu         (a_perdeu),
    .inimigo_vivo   (a_vivo),
    .nave_visivel   (a_vis),
    .vidas          (a_vidas),
    .pontos         (a_pontos),
    .atualizar      (a_atu)
  );

  controle_jogo #(.QUADROS_RESPAWN(1)) dut_b (
    .CLOCK_50       (clk),
    .reset          (rst),
    .frame_tick     (ft & sel),
    .start          (st & sel),
    .colisao_nave   (cn & sel),
    .colisao_inimigo(ci & sel),
    .ativo          (b_ativo),
    .perdeu         (b_perdeu),
    .inimigo_vivo   (b_vivo),
    .nave_visivel   (b_vis),
    .vidas          (b_vidas),
    .pontos         (b_pontos),
    .atualizar      (b_atu)
  );

  typedef struct {
    int          stamp;
    bit          b;
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic       e_ativo, e_perdeu, e_vivo, e_vis, e_atu;
  logic [2:0] e_vidas;
  logic [9:0] e_pontos;

  always @(posedge clk) cyc <= cyc + 1;

  // Packed field order: ativo perdeu vivo visivel vidas[2:0] pontos[9:0] atualizar
  exp_t        m_e;
  logic [17:0] m_got;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      m_e   = q.pop_front();
      m_got = m_e.b ? {b_ativo, b_perdeu, b_vivo, b_vis, b_vidas, b_pontos, b_atu}
                    : {a_ativo, a_perdeu, a_vivo, a_vis, a_vidas, a_pontos, a_atu};
      total++;
      if (m_e.stamp != cyc || m_got !== m_e.v)
        $display("FAIL %s: got a/p/v/n/vid/pts/upd=%b/%b/%b/%b/%0d/%0d/%b want %b/%b/%b/%b/%0d/%0d/%b",
                 m_e.name, m_got[17], m_got[16], m_got[15], m_got[14], m_got[13:11],
                 m_got[10:1], m_got[0], m_e.v[17], m_e.v[16], m_e.v[15], m_e.v[14],
                 m_e.v[13:11], m_e.v[10:1], m_e.v[0]);
      else
        passed++;
    end
  end

  task automatic step(input logic f, input logic s, input logic c, input logic i);
    ft = f; st = s; cn = c; ci = i;
    e_atu = f & e_ativo & ~e_perdeu & ~rst;
    @(posedge clk);
    #1;
    ft = 1'b0; cn = 1'b0; ci = 1'b0;
  endtask

  task automatic chk(input string n);
    exp_t e;
    e.stamp = cyc;
    e.b     = sel;
    e.v     = {e_ativo, e_perdeu, e_vivo, e_vis, e_vidas, e_pontos, e_atu};
    e.name  = n;
    q.push_back(e);
  endtask

  task automatic exp_reset();
    e_ativo = 0; e_perdeu = 0; e_vivo = 0; e_vis = 1; e_vidas = 0; e_pontos = 0; e_atu = 0;
  endtask

  initial begin
    rst = 1; sel = 0; ft = 0; st = 0; cn = 0; ci = 0;
    exp_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_a");
    sel = 1; chk("reset_b"); #1; sel = 0;
    rst = 0;

    // Start from idle
    step(0, 0, 0, 0);
    chk("idle");
    step(0, 1, 0, 0);
    e_ativo = 1; e_vidas = 3; e_vivo = 1;
    chk("start");

    // Ship hit, then invulnerability with ignored hits and blink
    step(0, 1, 1, 0);
    e_vidas = 2;
    chk("hit1");
    for (int i = 1; i <= 60; i++) begin
      step(1, 1, (i == 3 || i == 7), 0);
      e_vis = (i < 60) ? ~i[3] : 1'b1;
      chk($sformatf("invuln_t%0d", i));
    end

    // Enemy hit and respawn
    step(0, 1, 0, 1);
    e_pontos = 1; e_vivo = 0;
    chk("enemy_hit");
    step(0, 1, 0, 1);
    chk("enemy_hit_ignored");
    for (int i = 1; i <= 90; i++) begin
      step(1, 1, 0, 0);
      e_vivo = (i == 90);
      if (i >= 88) chk($sformatf("respawn_t%0d", i));
    end

    // Down to last life, then simultaneous fatal hit and score
    step(0, 1, 1, 0);
    e_vidas = 1;
    chk("hit2");
    for (int i = 1; i <= 60; i++) step(1, 1, 0, 0);
    e_vis = 1;
    chk("invuln2_end");
    step(0, 1, 1, 1);
    e_vidas = 0; e_pontos = 2; e_vivo = 0; e_perdeu = 1;
    chk("fatal_double");
    step(1, 1, 0, 0);
    chk("fim_no_update");
    step(0, 1, 1, 1);
    chk("fim_frozen");
    step(0, 0, 0, 0);
    chk("fim_start_low");
    step(0, 1, 0, 0);
    e_vidas = 3; e_pontos = 0; e_perdeu = 0; e_vivo = 1;
    chk("restart");

    // Reset during invulnerability with start held high
    step(0, 1, 1, 0);
    e_vidas = 2;
    chk("hit3");
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 0, 0);
      e_vis = ~i[3];
    end
    chk("invuln_blink_off");
    rst = 1;
    step(0, 1, 0, 0);
    exp_reset();
    chk("reset_mid");
    step(1, 1, 1, 1);
    chk("reset_hold");
    step(0, 0, 0, 0);
    chk("reset_start_low");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk($sformatf("post_reset_idle%0d", i));
    end
    step(0, 1, 0, 0);
    e_ativo = 1; e_vidas = 3; e_vivo = 1;
    chk("post_reset_start");

    // Score saturation on the fast-respawn instance
    step(0, 0, 0, 0);
    sel = 1;
    exp_reset();
    step(0, 0, 0, 0);
    chk("b_idle");
    step(0, 1, 0, 0);
    e_ativo = 1; e_vidas = 3; e_vivo = 1;
    chk("b_start");
    for (int k = 1; k <= 999; k++) begin
      step(0, 1, 0, 1);
      e_pontos = 10'(k); e_vivo = 0;
      if (k == 1 || k >= 998) chk($sformatf("b_hit%0d", k));
      step(1, 1, 0, 0);
      e_vivo = 1;
      if (k == 1 || k == 999) chk($sformatf("b_respawn%0d", k));
    end
    step(0, 1, 0, 1);
    e_vivo = 0;
    chk("b_saturate");
    step(1, 1, 0, 0);
    e_vivo = 1;
    chk("b_respawn_sat");
    step(0, 1, 0, 1);
    e_vivo = 0;
    chk("b_saturate2");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
      total++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
